trig_event_latch: RTL and testbench
===================================

# trig_event_latch

Sticky event collector for trigger-style pulse buses; the reading end of a trigger-out path. Each cycle a bit of `ep_trigger` is high counts as one event; events latch into sticky bits until a single-cycle read request snapshots them and atomically clears the sticky state. Events arriving during the read cycle are never lost. It sits between counter/status logic producing trigger vectors and the host-facing wire-out registers, all in the `sys_clk` domain.

## Interface
- `WIDTH`, default 32 — number of event channels, legal range 1..32.

- `sys_clk`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state immediately.
- `ep_trigger`  in  WIDTH  — event inputs; each cycle a bit is 1 counts as one event on that channel.
- `mask`  in  WIDTH  — per-channel enable; 0 drops events on that channel.
- `rd_req`  in  1  — snapshot-and-clear request, sampled every cycle.
- `rd_valid`  out  1  — one-cycle pulse marking fresh `rd_data`/`rd_ovf`/`rd_count`.
- `rd_data`  out  WIDTH  — snapshot of sticky bits; held until the next read.
- `rd_ovf`  out  WIDTH  — snapshot of overflow bits, meaning the channel saw ≥2 events since the last clear.
- `rd_count`  out  16  — snapshot of the event-cycle counter; constant 0 without `TRIG_LATCH_COUNT_EN`.
- `pending`  out  1  — 1 while any sticky bit is set.

## Operation
- Effective events: `ev = ep_trigger & mask`.
- Internal registers: `sticky[WIDTH]`, `ovf[WIDTH]`, `cnt[16]` (counter only with the macro).
- Cycle without `rd_req`:
  - `sticky <= sticky | ev`
  - `ovf <= ovf | (sticky & ev)`
  - `cnt <= sat(cnt + (|ev))`
- Cycle with `rd_req`:
  - `rd_data <= sticky | ev`
  - `rd_ovf <= ovf | (sticky & ev)`
  - `rd_count <= sat(cnt + (|ev))`
  - `sticky`, `ovf` and `cnt` cleared to 0.
  - Events in the request cycle go into the snapshot only. Events in the following cycle go into the cleared registers.
- Two bits set in the same cycle are not an overflow. A second event on the same bit in a later cycle is an overflow.
- Saturation: `cnt` stops at 16'hFFFF. Once saturated it does not wrap.
- Mask changes apply to future events only. Bits already sticky stay set until read.
- Back-to-back `rd_req` is legal. Every request cycle produces a `rd_valid` pulse and a fresh snapshot, which may be all zero.
- Two-state read sequencer:
  - IDLE: `rd_valid`=0.
  - REPLY: `rd_valid`=1 for exactly one cycle.
  - IDLE→REPLY on `rd_req`. REPLY→REPLY on `rd_req`, otherwise REPLY→IDLE.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_ovf`=0, `rd_count`=0, `pending`=0. Internal `sticky`, `ovf` and `cnt` are also 0.
- Read latency: `rd_req` high at edge N gives `rd_valid`=1 and new snapshot outputs visible after edge N (one cycle).
- `pending` is derived from registered `sticky`. It rises the cycle after the first event and falls the cycle after the clearing read.
  - If an event lands in the read cycle, it goes to the snapshot and `pending` still falls.
- Reset asserted mid-read (same cycle as `rd_req` or during REPLY):
  - Outputs go to reset values immediately; no `rd_valid` pulse is produced.
  - Events in that cycle are discarded.
- After reset deasserts, the first sampling edge already captures events.

## Configuration
- `TRIG_LATCH_COUNT_EN` defined:
  - `cnt` is built: a 16-bit saturating count of cycles with `|ev`=1.
  - It is snapshot to `rd_count` and cleared on read.
- Not defined:
  - No counter logic.
  - `rd_count` is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- Reset release: check all outputs are 0. Pulse `ep_trigger`=32'h0000_0001 with `mask`=all ones → `pending`=1 next cycle. Then `rd_req` → `rd_valid` one cycle later, `rd_data`=32'h1, `rd_ovf`=0, `pending`=0.
- Overflow: bit 3 pulsed in two separate cycles, and bits 4 and 5 together in one cycle, then read → `rd_data`=32'h38, `rd_ovf`=32'h08.
- Same-cycle event and read: sticky=32'h1, then bit 7 pulsed in the `rd_req` cycle → `rd_data`=32'h81. A read one cycle later returns `rd_data`=0.
- Mask: `mask`=32'hFFFF_FFFE, pulse bits 0 and 1 → read gives `rd_data`=32'h2. Clearing `mask` bit 1 after the event still returns bit 1.
- Counter (macro on): 70000 event cycles then read → `rd_count`=16'hFFFF; next read → 0. With the macro off, `rd_count`=0 always.
- Reset mid-read: assert `reset` during the `rd_req` cycle with sticky=32'hF → no `rd_valid` pulse, all outputs 0, and a subsequent read returns 0.

Source files
------------

// File: rtl/trig_event_latch_if.sv
// trig_event_latch_if: trigger-event bus joining event producers, the latch and its host read port.
interface trig_event_latch_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] ep_trigger, mask, rd_data, rd_ovf;
   logic rd_req, rd_valid, pending;
   logic [15:0] rd_count;
   modport master (output ep_trigger, mask, rd_req, input rd_valid, rd_data, rd_ovf, rd_count, pending);
   modport slave (input ep_trigger, mask, rd_req, output rd_valid, rd_data, rd_ovf, rd_count, pending);
endinterface

// File: rtl/trig_event_latch.sv
// trig_event_latch: sticky trigger-event collector with atomic snapshot-and-clear read.
// Define TRIG_LATCH_COUNT_EN to build the 16-bit saturating event-cycle counter.
module trig_event_latch #(parameter int WIDTH = 32) (
   input logic sys_clk,
   input logic reset,
   trig_event_latch_if.slave bus
);
   typedef enum logic {IDLE, REPLY} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] ev, sticky, ovf, sticky_nx, ovf_nx;
   assign ev = bus.ep_trigger & bus.mask;
   assign sticky_nx = sticky | ev;
   assign ovf_nx = ovf | (sticky & ev);
   assign bus.pending = |sticky;
   // Request-cycle events land in the snapshot; the live registers restart from zero.
   always_ff @(posedge sys_clk or posedge reset)
      if (reset) begin
         sticky <= '0;
         ovf <= '0;
         bus.rd_data <= '0;
         bus.rd_ovf <= '0;
      end else if (bus.rd_req) begin
         sticky <= '0;
         ovf <= '0;
         bus.rd_data <= sticky_nx;
         bus.rd_ovf <= ovf_nx;
      end else begin
         sticky <= sticky_nx;
         ovf <= ovf_nx;
      end
`ifdef TRIG_LATCH_COUNT_EN
   logic [15:0] cnt, cnt_nx;
   assign cnt_nx = &cnt ? cnt : cnt + 16'(|ev);
   always_ff @(posedge sys_clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         bus.rd_count <= '0;
      end else if (bus.rd_req) begin
         cnt <= '0;
         bus.rd_count <= cnt_nx;
      end else
         cnt <= cnt_nx;
`else
   assign bus.rd_count = 16'h0000;
`endif
   always_ff @(posedge sys_clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb state_nx = bus.rd_req ? REPLY : IDLE;
   always_comb bus.rd_valid = (state == REPLY);
endmodule

// File: tb/tb_trig_event_latch.sv
// tb_trig_event_latch: scoreboard bench; expected snapshots queue at each request, checked on rd_valid.
module tb_trig_event_latch;
   typedef struct {logic [31:0] d, o; logic [15:0] c;} exp_t;
   logic sys_clk = 0, reset = 1;
   int tests = 0, fails = 0;
   int unsigned ec = 0;
   exp_t sb[$];
   trig_event_latch_if #(.WIDTH(32)) bus ();
   trig_event_latch #(.WIDTH(32)) dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));
   always #5 sys_clk = ~sys_clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask
   // One cycle of stimulus; on a request the expected snapshot is queued.
   task automatic cyc(input logic [31:0] trig, input logic req, input logic [31:0] ed = 0, input logic [31:0] eo = 0);
      int unsigned c;
      c = (ec == 16'hFFFF) ? ec : ec + ((|(trig & bus.mask)) ? 1 : 0);
      bus.ep_trigger = trig;
      bus.rd_req = req;
      if (req) begin
`ifdef TRIG_LATCH_COUNT_EN
         sb.push_back('{ed, eo, 16'(c)});
`else
         sb.push_back('{ed, eo, 16'h0});
`endif
         ec = 0;
      end else ec = c;
      @(posedge sys_clk);
      #1;
      bus.ep_trigger = '0;
      bus.rd_req = 0;
   endtask
   always @(negedge sys_clk)
      if (!reset && bus.rd_valid) begin
         if (sb.size() == 0) check("sb_unexpected_valid", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("rd_data", bus.rd_data, e.d);
            check("rd_ovf", bus.rd_ovf, e.o);
            check("rd_count", 32'(bus.rd_count), 32'(e.c));
         end
      end
   initial begin
      bus.ep_trigger = '0;
      bus.mask = '1;
      bus.rd_req = 0;
      repeat (3) @(posedge sys_clk);
      #1;
      reset = 0;
      check("rst_valid", 32'(bus.rd_valid), 0);
      check("rst_data", bus.rd_data, 0);
      check("rst_ovf", bus.rd_ovf, 0);
      check("rst_count", 32'(bus.rd_count), 0);
      check("rst_pending", 32'(bus.pending), 0);
      cyc(32'h1, 0);
      check("pending_rise", 32'(bus.pending), 1);
      cyc(0, 1, 32'h1, 0);
      check("pending_fall", 32'(bus.pending), 0);
      cyc(32'h8, 0);
      cyc(32'h8, 0);
      cyc(32'h30, 0);
      cyc(0, 1, 32'h38, 32'h08);
      cyc(32'h1, 0);
      cyc(32'h80, 1, 32'h81, 0);
      check("pending_read_ev", 32'(bus.pending), 0);
      cyc(0, 1, 0, 0);
      cyc(32'h4, 0);
      cyc(32'h4, 1, 32'h4, 32'h4);
      cyc(32'h4, 0);
      cyc(0, 1, 32'h4, 0);
      bus.mask = 32'hFFFF_FFFE;
      cyc(32'h3, 0);
      bus.mask = 32'hFFFF_FFFC;
      cyc(0, 1, 32'h2, 0);
      bus.mask = '1;
      cyc(32'hF, 0);
      check("pending_pre_rst", 32'(bus.pending), 1);
      bus.rd_req = 1;
      bus.ep_trigger = 32'h10;
      reset = 1;
      #1;
      check("midrd_valid", 32'(bus.rd_valid), 0);
      check("midrd_data", bus.rd_data, 0);
      check("midrd_ovf", bus.rd_ovf, 0);
      check("midrd_count", 32'(bus.rd_count), 0);
      check("midrd_pending", 32'(bus.pending), 0);
      @(posedge sys_clk);
      #1;
      reset = 0;
      bus.rd_req = 0;
      bus.ep_trigger = '0;
      ec = 0;
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 70000; i++) cyc(32'h1, 0);
      cyc(0, 1, 32'h1, 32'h1);
      cyc(0, 1, 0, 0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      check("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
